// File: rtl/square_osc_pkg.sv
// Shared types and constants for the multi-channel square wave oscillator.
package square_osc_pkg;

  // Per-channel oscillator state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } chan_state_t;

  // Signed 16-bit audio sample.
  typedef logic signed [15:0] signal_t;

  // Largest positive sample; the mix saturates here instead of wrapping.
  localparam int SAT_MAX = 32767;

  // Clamp an elaboration-time step size so slewing always makes progress.
  function automatic int min_one(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/square_osc_channel.sv
// One oscillator channel: IDLE/HIGH/LOW state machine with a phase down-counter.
// Phase lengths are sampled only at phase boundaries, so a running phase is never cut short.
module square_osc_channel
  import square_osc_pkg::*;
#(
  parameter int COUNT_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   I_RST,
  input  logic                   enable,
  input  logic [COUNT_WIDTH-1:0] high_count,
  input  logic [COUNT_WIDTH-1:0] low_count,
  output logic                   phase
);

  chan_state_t            state_reg, state_next;
  logic [COUNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic [COUNT_WIDTH-1:0] high_load, low_load;

  // A programmed length of 0 behaves like 1, so the reload value floors at 0.
  assign high_load = (high_count == '0) ? '0 : high_count - COUNT_WIDTH'(1);
  assign low_load  = (low_count  == '0) ? '0 : low_count  - COUNT_WIDTH'(1);

  // State and counter registers; reset aborts any phase in progress.
  always_ff @(posedge clk or posedge I_RST) begin
    if (I_RST) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: disabling wins over a simultaneous phase boundary.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (enable) begin
          state_next = HIGH;
          cnt_next   = high_load;
        end
      end
      HIGH: begin
        if (!enable) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == '0) begin
          state_next = LOW;
          cnt_next   = low_load;
        end else begin
          cnt_next = cnt_reg - COUNT_WIDTH'(1);
        end
      end
      LOW: begin
        if (!enable) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == '0) begin
          state_next = HIGH;
          cnt_next   = high_load;
        end else begin
          cnt_next = cnt_reg - COUNT_WIDTH'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign phase = (state_reg == HIGH);

endmodule

// File: rtl/multi_channel_square_wave_oscillator.sv
// Multi-channel square wave oscillator: CHANNELS independent square waves are
// summed into one saturated signed 16-bit sample on each audio strobe.
// Optional feature macro SQUARE_OSC_SLEW_EN: when defined, the output moves
// toward the mixed target by at most MAX_STEP per strobe; otherwise it tracks
// the target directly.
module multi_channel_square_wave_oscillator
  import square_osc_pkg::*;
#(
  parameter int  CHANNELS              = 2,
  parameter int  SIGNAL_FRACTION_WIDTH = 14,
  parameter real VCC                   = 12.0,
  parameter real HIGH_VOLTAGE          = 5.0,
  parameter real SAMPLE_RATE           = 48000.0,
  parameter real MAX_CHANGE_RATE       = 10000.0,
  parameter int  COUNT_WIDTH           = 24
) (
  input  logic                            clk,
  input  logic                            I_RST,
  input  logic                            audio_clk_en,
  input  logic [CHANNELS-1:0]             enable,
  input  logic [CHANNELS*COUNT_WIDTH-1:0] high_count,
  input  logic [CHANNELS*COUNT_WIDTH-1:0] low_count,
  output logic [CHANNELS-1:0]             phase,
  output logic signed [15:0]              out
);

  localparam real         FULL_SCALE   = 2.0 ** SIGNAL_FRACTION_WIDTH;
  localparam int          HIGH_LEVEL   = $rtoi(FULL_SCALE * HIGH_VOLTAGE / VCC);
  localparam logic [19:0] HIGH_LEVEL_W = 20'(HIGH_LEVEL);

  logic [3:0]  pop_count;
  logic [19:0] mix_sum;
  signal_t     mix_sat;
  signal_t     target_reg;

  // One oscillator per channel, each on its own slice of the count buses.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    square_osc_channel #(
      .COUNT_WIDTH(COUNT_WIDTH)
    ) u_ch (
      .clk       (clk),
      .I_RST     (I_RST),
      .enable    (enable[gi]),
      .high_count(high_count[gi*COUNT_WIDTH +: COUNT_WIDTH]),
      .low_count (low_count[gi*COUNT_WIDTH +: COUNT_WIDTH]),
      .phase     (phase[gi])
    );
  end

  // Mix: count the high channels, scale, and clamp at the positive rail.
  always_comb begin
    pop_count = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pop_count = pop_count + 4'(phase[i]);
    end
    mix_sum = 20'(pop_count) * HIGH_LEVEL_W;
    mix_sat = (mix_sum > 20'(SAT_MAX)) ? signal_t'(SAT_MAX) : signal_t'(mix_sum[15:0]);
  end

  // Target sample latches only on the audio strobe.
  always_ff @(posedge clk or posedge I_RST) begin
    if (I_RST) begin
      target_reg <= '0;
    end else if (audio_clk_en) begin
      target_reg <= mix_sat;
    end
  end

`ifdef SQUARE_OSC_SLEW_EN
  localparam int                 MAX_STEP = min_one($rtoi(MAX_CHANGE_RATE / SAMPLE_RATE * FULL_SCALE / VCC));
  localparam int                 STEP_CL  = (MAX_STEP > 65535) ? 65535 : MAX_STEP;
  localparam logic signed [17:0] STEP_S   = 18'(STEP_CL);

  signal_t            out_reg, slew_next;
  logic signed [17:0] diff, step_sum;

  // Slew limiter: move toward the latched target by at most one step.
  always_comb begin
    diff      = 18'(target_reg) - 18'(out_reg);
    step_sum  = '0;
    slew_next = target_reg;
    if (diff > STEP_S) begin
      step_sum  = 18'(out_reg) + STEP_S;
      slew_next = signal_t'(step_sum[15:0]);
    end else if (diff < -STEP_S) begin
      step_sum  = 18'(out_reg) - STEP_S;
      slew_next = signal_t'(step_sum[15:0]);
    end
  end

  // Output register advances only on the audio strobe.
  always_ff @(posedge clk or posedge I_RST) begin
    if (I_RST) begin
      out_reg <= '0;
    end else if (audio_clk_en) begin
      out_reg <= slew_next;
    end
  end

  assign out = out_reg;
`else
  assign out = target_reg;
`endif

endmodule

// File: tb/tb_multi_channel_square_wave_oscillator.sv
// Scoreboard bench: stimulus pushes the expected post-edge outputs, a negedge
// monitor pops and compares them.
module tb_multi_channel_square_wave_oscillator;

`ifdef SQUARE_OSC_SLEW_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               I_RST;
  logic               audio_clk_en;
  logic [1:0]         enable;
  logic [47:0]        high_count, low_count;
  logic [1:0]         phase2;
  logic signed [15:0] out2;
  logic [7:0]         en8;
  logic [191:0]       high8, low8;
  logic [7:0]         phase8;
  logic signed [15:0] out8;

  multi_channel_square_wave_oscillator dut (
    .clk(clk), .I_RST(I_RST), .audio_clk_en(audio_clk_en), .enable(enable),
    .high_count(high_count), .low_count(low_count), .phase(phase2), .out(out2)
  );

  multi_channel_square_wave_oscillator #(
    .CHANNELS(8), .HIGH_VOLTAGE(12.0), .MAX_CHANGE_RATE(2.0e6)
  ) dut8 (
    .clk(clk), .I_RST(I_RST), .audio_clk_en(audio_clk_en), .enable(en8),
    .high_count(high8), .low_count(low8), .phase(phase8), .out(out8)
  );

  typedef struct {
    bit         sel;
    logic [7:0] ph;
    int         o;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_out = 0;

  task automatic chk(input string nm, input int act, input int expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end else begin
      $display("ok   %s: %0d", nm, act);
    end
  endtask

  // Monitor: every negedge, compare all expectations queued since the last edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.sel) begin
        chk({e.nm, "_phase8"}, int'(phase8), int'(e.ph));
        chk({e.nm, "_out8"}, int'(out8), e.o);
      end else begin
        chk({e.nm, "_phase"}, int'(phase2), int'(e.ph));
        chk({e.nm, "_out"}, int'(out2), e.o);
      end
    end
  end

  task automatic cyc(input bit sel, input logic [7:0] ph, input int o, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    e.sel = sel; e.ph = ph; e.o = o; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic run(input int n, input logic [7:0] ph, input string nm);
    for (int i = 0; i < n; i++) cyc(1'b0, ph, exp_out, nm);
  endtask

  initial begin
    I_RST = 1'b1; audio_clk_en = 1'b0; enable = 2'b00; en8 = 8'h00;
    high_count = {24'd3, 24'd3};
    low_count  = {24'd5, 24'd5};
    for (int c = 0; c < 8; c++) begin
      high8[c*24 +: 24] = 24'd100;
      low8[c*24 +: 24]  = 24'd5;
    end
    cyc(1'b0, 8'h00, 0, "reset");
    cyc(1'b1, 8'h00, 0, "reset8");

    // 3 high / 5 low on channel 0, channel 1 held off
    I_RST = 1'b0; enable = 2'b01;
    for (int p = 0; p < 2; p++) begin
      run(3, 8'h01, "p_high3");
      run(5, 8'h00, "p_low5");
    end

    // high_count raised mid-HIGH: current phase keeps 3, next is 7
    run(1, 8'h01, "hc_mid");
    high_count[23:0] = 24'd7;
    run(2, 8'h01, "hc_keep3");
    run(5, 8'h00, "hc_low5");
    run(7, 8'h01, "hc_new7");
    run(4, 8'h00, "hc_low5b");
    high_count[23:0] = 24'd3;
    run(1, 8'h00, "hc_low5b");

    // enable dropped exactly on the HIGH->LOW boundary
    run(2, 8'h01, "drop_high");
    run(1, 8'h01, "drop_bound");
    enable = 2'b00;
    run(1, 8'h00, "drop_idle");
    run(2, 8'h00, "idle_hold");
    enable = 2'b01;
    run(3, 8'h01, "reen_high3");
    run(1, 8'h00, "reen_low");
    enable = 2'b00;
    run(1, 8'h00, "to_idle");

`ifndef SQUARE_OSC_SLEW_EN
    // single channel mix, then strobe in LOW returns to 0
    enable = 2'b01;
    run(1, 8'h01, "mix1_high");
    audio_clk_en = 1'b1; exp_out = 6826;
    run(1, 8'h01, "mix1_6826");
    audio_clk_en = 1'b0;
    run(1, 8'h01, "mix1_hold");
    run(1, 8'h00, "mix1_hold_low");
    audio_clk_en = 1'b1; exp_out = 0;
    run(1, 8'h00, "mix1_zero");
    audio_clk_en = 1'b0;
    run(3, 8'h00, "mix1_low");
    enable = 2'b00;
    run(1, 8'h00, "mix1_idle");
`endif

    // both channels high, repeated strobes
    high_count = {24'd100, 24'd100};
    enable = 2'b11;
    run(1, 8'h03, "mix2_start");
    audio_clk_en = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      if (SLEW) exp_out = (284 * (k - 1) > 13652) ? 13652 : 284 * (k - 1);
      else      exp_out = 13652;
      cyc(1'b0, 8'h03, exp_out, "mix2");
    end
    audio_clk_en = 1'b0; enable = 2'b00;
    run(1, 8'h00, "mix2_idle");

    // zero high_count gives one-cycle highs; reset mid-LOW
    high_count = {24'd3, 24'd0};
    low_count  = {24'd5, 24'd2};
    enable = 2'b01;
    run(1, 8'h01, "hc0_high1");
    run(2, 8'h00, "hc0_low2");
    run(1, 8'h01, "hc0_high1b");
    run(1, 8'h00, "mid_low");
    @(negedge clk);
    #2 I_RST = 1'b1;
    #1;
    chk("async_phase", int'(phase2), 0);
    chk("async_out", int'(out2), 0);
    exp_out = 0;
    high_count[23:0] = 24'd3;
    low_count[23:0]  = 24'd5;
    run(1, 8'h00, "rst_hold");
    I_RST = 1'b0;
    run(3, 8'h01, "restart_high3");
    run(1, 8'h00, "restart_low");
    enable = 2'b00;

    // 8 channels at full-scale level: saturation, no wrap
    en8 = 8'h01;
    cyc(1'b1, 8'h01, 0, "sat_en1");
    audio_clk_en = 1'b1;
    cyc(1'b1, 8'h01, SLEW ? 0 : 16384, "sat_one");
    cyc(1'b1, 8'h01, 16384, "sat_one_b");
    audio_clk_en = 1'b0; en8 = 8'hFF;
    cyc(1'b1, 8'hFF, 16384, "sat_all_en");
    audio_clk_en = 1'b1;
    cyc(1'b1, 8'hFF, SLEW ? 16384 : 32767, "sat_all");
    cyc(1'b1, 8'hFF, 32767, "sat_all_b");
    audio_clk_en = 1'b0;
    cyc(1'b1, 8'hFF, 32767, "sat_hold");

    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multi_channel_square_wave_oscillator.md
MULTI_CHANNEL_SQUARE_WAVE_OSCILLATOR -- requirements
Module: multi_channel_square_wave_oscillator

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent oscillator channels, range 1..8.
REQ-002 Parameter SIGNAL_FRACTION_WIDTH, default 14: VCC maps to 1<<SIGNAL_FRACTION_WIDTH.
REQ-003 Parameters VCC, default 12.0 [V], and HIGH_VOLTAGE, default 5.0 [V]: supply voltage and per-channel high-level voltage.
REQ-004 Parameters SAMPLE_RATE, default 48000 [Hz], and MAX_CHANGE_RATE, default 10000 [V/s]: inputs to the slew step.
REQ-005 Parameter COUNT_WIDTH, default 24: width of each phase-length field.
REQ-006 clk  input  1  system clock.
REQ-007 I_RST  input  1  asynchronous, active-high reset.
REQ-008 audio_clk_en  input  1  one-cycle sample strobe.
REQ-009 enable  input  CHANNELS  per-channel gate; 1 = oscillate.
REQ-010 high_count  input  CHANNELS*COUNT_WIDTH  per-channel high-phase length in clk cycles; channel i uses slice [i*COUNT_WIDTH +: COUNT_WIDTH].
REQ-011 low_count  input  CHANNELS*COUNT_WIDTH  per-channel low-phase length in clk cycles; same slicing as high_count.
REQ-012 phase  output  CHANNELS  raw per-channel level; 1 = high.
REQ-013 out  output  16 signed  mixed, slew-limited audio sample.

Function
REQ-014 Each channel SHALL run an FSM with states IDLE, HIGH, LOW and a COUNT_WIDTH down-counter.
REQ-015 IDLE with enable=1 SHALL move to HIGH on the next clk and load high_count-1 into the counter.
REQ-016 HIGH/LOW with counter=0 SHALL toggle to the other phase and load (low_count-1) or (high_count-1), sampled on that same edge; otherwise the counter SHALL decrement.
REQ-017 A count value of 0 SHALL be treated as 1, so every phase lasts at least one cycle.
REQ-018 Count changes SHALL take effect only at the next phase boundary; a phase in progress is never cut short.
REQ-019 enable=0 in HIGH or LOW SHALL force IDLE on the next clk (phase=0), overriding a simultaneous boundary.
REQ-020 phase[i] SHALL be 1 exactly in state HIGH; a full period is high_count+low_count cycles.
REQ-021 HIGH_LEVEL = floor((1<<SIGNAL_FRACTION_WIDTH)*HIGH_VOLTAGE/VCC), computed at elaboration; 6826 at defaults.
REQ-022 On each audio_clk_en, target SHALL latch popcount(phase)*HIGH_LEVEL, saturated to 32767 and computed in 20 bits.
REQ-023 out SHALL NOT change between audio_clk_en strobes.

Reset
REQ-024 While I_RST=1, all channels SHALL be IDLE with counters 0, and phase, target and out SHALL be 0.
REQ-025 Reset asserted mid-phase SHALL abort immediately; after release, a channel with enable=1 SHALL restart in HIGH with a full high phase.

Configuration
REQ-026 MAX_STEP = floor(MAX_CHANGE_RATE/SAMPLE_RATE*(1<<SIGNAL_FRACTION_WIDTH)/VCC), minimum 1; 284 at defaults.
REQ-027 With SQUARE_OSC_SLEW_EN defined, on each audio_clk_en out SHALL move toward target by min(|target-out|, MAX_STEP).
REQ-028 Without SQUARE_OSC_SLEW_EN, out SHALL equal target, updated one clk after audio_clk_en.

Structure
REQ-029 Package square_osc_pkg SHALL hold the channel-state enum (IDLE/HIGH/LOW), the signal_t typedef (signed 16) and the saturation constant 32767.
REQ-030 Per-channel FSM and counter SHALL be sub-module square_osc_channel, instantiated CHANNELS times by generate; mixing and slew live in the top.

Verification
REQ-031 Bench: CHANNELS=2, enable=01, high=3, low=5 -> phase[0] repeats 3 high / 5 low cycles; phase[1] stays 0.
REQ-032 Bench: high_count changed 3->7 mid-HIGH -> current high phase stays 3 cycles; the next high phase is 7.
REQ-033 Bench: enable dropped on the same cycle as a HIGH->LOW boundary -> IDLE next clk, phase=0; re-enable -> full 3-cycle high phase.
REQ-034 Bench: both channels high, strobe, slew off -> out=13652; slew on -> out steps 284 per strobe (0, 284, 568, ...) until 13652.
REQ-035 Bench: CHANNELS=8, HIGH_VOLTAGE=12 -> all high saturates target at 32767, no wrap.
REQ-036 Bench: I_RST pulsed mid-LOW -> phase=0 and out=0 asynchronously, without waiting for a clk edge; high_count=0 -> one-cycle high phases.
